// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer SRAM read-back path.
// Contents: SQI command/phase constants, capture-size limit and the
// reader state enum used by la_sram_reader.
package la_pkg;

    localparam logic [7:0]  SQI_CMD_READ   = 8'h03;
    localparam logic [15:0] LA_MAX_SAMPLES = 16'hF424;
    localparam int          SQI_CMD_CLKS   = 2;
    localparam int          SQI_ADDR_CLKS  = 6;
    localparam int          SQI_DUMMY_CLKS = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_DONE
    } rd_state_e;

endpackage

// File: rtl/la_read_fifo.sv
// Small synchronous show-ahead FIFO for reassembled capture words.
// Ports:
//   clock, reset      - system clock, sync active-high reset
//   flush             - sync clear of all contents
//   push, push_data   - write request / data
//   pop               - read request; ignored when empty
//   data, valid       - head word (zero when empty) / non-empty flag
//   count             - current occupancy, 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module la_read_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic [CW-1:0]    count
);
    import la_pkg::*;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is allowed when the head leaves in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign valid   = (count != '0);
    assign data    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/la_sram_reader.sv
// SQI read-back engine for the two logic-analyzer capture SRAMs.
// Issues READ (0x03) + 24-bit address + 2 dummy clocks to both chips in
// lockstep, then captures one 8-bit sample per SPI clock (chip0 = sio[3:0],
// chip1 = sio[7:4]) and queues 16-bit words for the MCU register path.
// Optional feature macro: LA_READ_PACK_EN - packs two samples per word
// (first in [7:0], second in [15:8]); otherwise each word is {8'h00, sample}.
// Ports:
//   clock, reset              - system clock, sync active-high reset
//   start, start_addr,
//   sample_count              - read request (latched in IDLE only)
//   abort                     - sync cancel, flushes partial word and FIFO
//   busy, done                - CS-active flag / one-cycle completion pulse
//   sram_clock, sram_cs       - SQI clock and active-low selects per chip
//   sio_oe, sio_out, sio_in   - SQI data pin control
//   word_data, word_valid,
//   word_ready                - show-ahead word stream to the register path
module la_sram_reader
    import la_pkg::*;
#(
    parameter int LA_WIDTH   = 8,
    parameter int LA_CHIPS   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [23:0]         start_addr,
    input  logic [15:0]         sample_count,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [LA_CHIPS-1:0] sram_clock,
    output logic [LA_CHIPS-1:0] sram_cs,
    output logic                sio_oe,
    output logic [LA_WIDTH-1:0] sio_out,
    input  logic [LA_WIDTH-1:0] sio_in,
    output logic [15:0]         word_data,
    output logic                word_valid,
    input  logic                word_ready
);

    localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

    rd_state_e   state, state_n;
    logic        phase, phase_n;          // 0 = SPI clock low, 1 = high
    logic [2:0]  cnt, cnt_n;              // SPI clocks done in current phase
    logic [15:0] remaining, remaining_n;
    logic [23:0] addr, addr_n;
    logic [7:0]  partial, partial_n;
    logic        have_partial, have_partial_n;

    logic          push;
    logic [15:0]   push_data;
    logic [CW-1:0] fifo_count;
    logic [7:0]    sample;
    logic [3:0]    nibble;
    logic [23:0]   addr_shift;
    logic          active;

    assign sample     = sio_in[7:0];
    assign addr_shift = addr << {cnt, 2'b00};

    always_comb begin
        nibble = 4'h0;
        if (state == ST_CMD)
            nibble = (cnt == 3'd0) ? SQI_CMD_READ[7:4] : SQI_CMD_READ[3:0];
        else if (state == ST_ADDR)
            nibble = addr_shift[23:20];
    end

    assign active     = (state == ST_CMD) || (state == ST_ADDR) ||
                        (state == ST_DUMMY) || (state == ST_DATA);
    assign busy       = active;
    assign done       = (state == ST_DONE);
    assign sram_cs    = {LA_CHIPS{~active}};
    assign sram_clock = {LA_CHIPS{active & phase}};
    assign sio_oe     = (state == ST_CMD) || (state == ST_ADDR);
    assign sio_out    = {LA_CHIPS{nibble}};

    always_comb begin
        state_n        = state;
        phase_n        = phase;
        cnt_n          = cnt;
        remaining_n    = remaining;
        addr_n         = addr;
        partial_n      = partial;
        have_partial_n = have_partial;
        push           = 1'b0;
        push_data      = '0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    addr_n         = start_addr;
                    remaining_n    = sample_count;
                    cnt_n          = '0;
                    phase_n        = 1'b0;
                    have_partial_n = 1'b0;
                    state_n        = (sample_count == 16'd0) ? ST_DONE : ST_CMD;
                end
            end
            ST_CMD, ST_ADDR, ST_DUMMY: begin
                phase_n = ~phase;
                if (phase) begin
                    cnt_n = cnt + 3'd1;
                    if (state == ST_CMD && cnt == 3'(SQI_CMD_CLKS - 1)) begin
                        cnt_n   = '0;
                        state_n = ST_ADDR;
                    end else if (state == ST_ADDR && cnt == 3'(SQI_ADDR_CLKS - 1)) begin
                        cnt_n   = '0;
                        state_n = ST_DUMMY;
                    end else if (state == ST_DUMMY && cnt == 3'(SQI_DUMMY_CLKS - 1)) begin
                        cnt_n   = '0;
                        state_n = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (!phase) begin
                    // Only raise the clock when the resulting sample has room.
                    if (fifo_count < FIFO_FULL) phase_n = 1'b1;
                end else begin
                    phase_n     = 1'b0;
                    remaining_n = remaining - 16'd1;
`ifdef LA_READ_PACK_EN
                    if (have_partial) begin
                        push           = 1'b1;
                        push_data      = {sample, partial};
                        have_partial_n = 1'b0;
                    end else if (remaining == 16'd1) begin
                        push      = 1'b1;
                        push_data = {8'h00, sample};
                    end else begin
                        partial_n      = sample;
                        have_partial_n = 1'b1;
                    end
`else
                    push      = 1'b1;
                    push_data = {8'h00, sample};
`endif
                    if (remaining == 16'd1) state_n = ST_DONE;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase

        if (abort) begin
            state_n        = ST_IDLE;
            phase_n        = 1'b0;
            cnt_n          = '0;
            have_partial_n = 1'b0;
            push           = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            phase        <= 1'b0;
            cnt          <= '0;
            remaining    <= '0;
            addr         <= '0;
            partial      <= '0;
            have_partial <= 1'b0;
        end else begin
            state        <= state_n;
            phase        <= phase_n;
            cnt          <= cnt_n;
            remaining    <= remaining_n;
            addr         <= addr_n;
            partial      <= partial_n;
            have_partial <= have_partial_n;
        end
    end

    la_read_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (abort),
        .push      (push),
        .push_data (push_data),
        .pop       (word_ready),
        .data      (word_data),
        .valid     (word_valid),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_la_sram_reader.sv
// Directed bench for la_sram_reader with a behavioural SQI SRAM pair that
// returns byte (i+1)*0x11 for the i-th data clock after CS falls.
module tb_la_sram_reader;

    localparam int LA_WIDTH   = 8;
    localparam int LA_CHIPS   = 2;
    localparam int FIFO_DEPTH = 4;
`ifdef LA_READ_PACK_EN
    localparam int PACK = 1;
`else
    localparam int PACK = 0;
`endif

    logic                clock = 1'b0;
    logic                reset, start, abort, word_ready;
    logic [23:0]         start_addr;
    logic [15:0]         sample_count;
    logic                busy, done, sio_oe, word_valid;
    logic [LA_CHIPS-1:0] sram_clock, sram_cs;
    logic [LA_WIDTH-1:0] sio_out;
    logic [LA_WIDTH-1:0] sio_in = '0;
    logic [15:0]         word_data;

    int checks = 0;
    int errors = 0;
    int e, first_valid, done_edge, d0;
    int done_cnt = 0;
    int clk_n    = 0;
    int dclk     = 0;
    bit cs_low_seen;
    bit rep_bad;
    logic [3:0]  nibs[$];
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];

    always #5 clock = ~clock;

    la_sram_reader #(
        .LA_WIDTH   (LA_WIDTH),
        .LA_CHIPS   (LA_CHIPS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .start_addr   (start_addr),
        .sample_count (sample_count),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .sram_clock   (sram_clock),
        .sram_cs      (sram_cs),
        .sio_oe       (sio_oe),
        .sio_out      (sio_out),
        .sio_in       (sio_in),
        .word_data    (word_data),
        .word_valid   (word_valid),
        .word_ready   (word_ready)
    );

    function automatic logic [7:0] sb(input int i);
        return 8'((i + 1) * 17);
    endfunction

    // SRAM model, done counter and word collector, all on the falling edge.
    always @(negedge clock) begin
        if (done) done_cnt++;
        if (word_valid && word_ready) got_q.push_back(word_data);
        if (sram_cs[0]) begin
            clk_n = 0;
            dclk  = 0;
        end else if (sram_clock[0]) begin
            if (clk_n < 8) begin
                nibs.push_back(sio_out[3:0]);
                if (sio_out[7:4] != sio_out[3:0]) rep_bad = 1'b1;
            end
            if (clk_n >= 10) begin
                sio_in = sb(dclk);
                dclk++;
            end
            clk_n++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        e++;
    endtask

    task automatic start_read(input logic [23:0] a, input logic [15:0] n);
        start_addr   = a;
        sample_count = n;
        start        = 1'b1;
        nibs.delete();
        got_q.delete();
        rep_bad  = 1'b0;
        done_cnt = 0;
        @(posedge clock);
        #1;
        start       = 1'b0;
        e           = 0;
        first_valid = -1;
        done_edge   = -1;
        cs_low_seen = 1'b0;
    endtask

    task automatic wait_done(input string t, input int budget);
        while (done_edge < 0 && e < budget) begin
            if (word_valid && first_valid < 0) first_valid = e;
            if (sram_cs !== {LA_CHIPS{1'b1}}) cs_low_seen = 1'b1;
            if (done) begin
                done_edge = e;
                chk({t, "_done_cs"}, sram_cs, {LA_CHIPS{1'b1}});
                chk({t, "_done_busy"}, busy, 0);
            end else begin
                step();
            end
        end
        if (done_edge < 0) chk({t, "_done_seen"}, done, 1);
    endtask

    task automatic drain();
        repeat (3 * FIFO_DEPTH) step();
    endtask

    task automatic build_exp(input int n);
        exp_q.delete();
        if (PACK != 0) begin
            for (int i = 0; i < n; i += 2)
                exp_q.push_back({(i + 1 < n) ? sb(i + 1) : 8'h00, sb(i)});
        end else begin
            for (int i = 0; i < n; i++) exp_q.push_back({8'h00, sb(i)});
        end
    endtask

    task automatic cmp_words(input string t);
        chk({t, "_nwords"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_w%0d", t, i), got_q[i], exp_q[i]);
    endtask

    task automatic chk_nibs(input string t, input logic [31:0] exp);
        logic [31:0] nv;
        nv = '0;
        for (int i = 0; i < 8 && i < nibs.size(); i++) nv = {nv[27:0], nibs[i]};
        chk({t, "_nnib"}, nibs.size(), 8);
        chk({t, "_nibs"}, nv, exp);
        chk({t, "_rep"}, rep_bad, 0);
    endtask

    task automatic chk_reset(input string t);
        chk({t, "_cs"},    sram_cs, {LA_CHIPS{1'b1}});
        chk({t, "_sclk"},  sram_clock, 0);
        chk({t, "_oe"},    sio_oe, 0);
        chk({t, "_sout"},  sio_out, 0);
        chk({t, "_busy"},  busy, 0);
        chk({t, "_done"},  done, 0);
        chk({t, "_valid"}, word_valid, 0);
        chk({t, "_data"},  word_data, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required finish earlier");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        word_ready   = 1'b1;
        start_addr   = '0;
        sample_count = '0;
        e            = 0;
        repeat (3) @(posedge clock);
        #1;
        chk_reset("rst");
        reset = 1'b0;
        step();

        // Basic 4-sample read
        start_read(24'h000100, 16'd4);
        chk("t1_busy", busy, 1);
        chk("t1_cs",   sram_cs, 0);
        chk("t1_oe",   sio_oe, 1);
        chk("t1_sout", sio_out, 0);
        wait_done("t1", 300);
        drain();
        chk_nibs("t1", 32'h03000100);
        chk("t1_first", first_valid, (PACK != 0) ? 24 : 22);
        chk("t1_done_e", done_edge, 28);
        chk("t1_done_n", done_cnt, 1);
        build_exp(4);
        cmp_words("t1");

        // Odd count
        start_read(24'h000200, 16'd3);
        wait_done("t2", 300);
        drain();
        chk("t2_done_e", done_edge, 26);
        build_exp(3);
        cmp_words("t2");

        // Zero count
        start_read(24'h000300, 16'd0);
        wait_done("t3", 20);
        drain();
        chk("t3_done_e", done_edge, 0);
        chk("t3_cs_low", cs_low_seen, 0);
        chk("t3_done_n", done_cnt, 1);
        chk("t3_nwords", got_q.size(), 0);

        // Backpressure
        word_ready = 1'b0;
        start_read(24'h000000, 16'd16);
        repeat (150) step();
        build_exp(16);
        chk("st_sclk",  sram_clock, 0);
        chk("st_cs",    sram_cs, 0);
        chk("st_busy",  busy, 1);
        chk("st_valid", word_valid, 1);
        chk("st_dclk",  dclk, FIFO_DEPTH * (PACK + 1));
        chk("st_head",  word_data, exp_q[0]);
        d0 = dclk;
        repeat (20) step();
        chk("st_frozen", dclk, d0);
        word_ready = 1'b1;
        wait_done("st", 1500);
        drain();
        cmp_words("st");
        chk("st_done_n", done_cnt, 1);

        // Abort at the third data sample, then a normal read
        start_read(24'h000000, 16'd8);
        while (dclk < 3 && e < 100) step();
        chk("ab_reached", dclk, 3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_cs",    sram_cs, {LA_CHIPS{1'b1}});
        chk("ab_sclk",  sram_clock, 0);
        chk("ab_oe",    sio_oe, 0);
        chk("ab_valid", word_valid, 0);
        chk("ab_busy",  busy, 0);
        repeat (10) step();
        chk("ab_done_n", done_cnt, 0);
        start_read(24'h000010, 16'd2);
        wait_done("ab2", 300);
        drain();
        chk("ab2_done_e", done_edge, 24);
        build_exp(2);
        cmp_words("ab2");

        // Reset during ADDR
        start_read(24'h123456, 16'd4);
        repeat (6) step();
        chk("ra_oe_pre", sio_oe, 1);
        reset = 1'b1;
        step();
        chk_reset("ra");
        reset = 1'b0;
        repeat (4) step();
        chk("ra_done_n", done_cnt, 0);

        // Start while busy is ignored
        start_read(24'h000100, 16'd2);
        step();
        step();
        start_addr   = 24'hABCDEF;
        sample_count = 16'd9;
        start        = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("sb", 300);
        drain();
        chk_nibs("sb", 32'h03000100);
        chk("sb_done_e", done_edge, 24);
        chk("sb_done_n", done_cnt, 1);
        build_exp(2);
        cmp_words("sb");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
